// File: rtl/fx_invcdf_sqrt_if.sv
// Handshake bundle for the fx_invcdf_sqrt square-root stage.
// The master drives samples in and the slave returns the root with its tail flag.
`default_nettype none

interface fx_invcdf_sqrt_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic [WIDTH-1:0] x;
  logic             negate_in;
  logic             in_ready;
  logic             valid_out;
  logic [WIDTH-1:0] t;
  logic             negate_out;

  modport master (
    output valid_in, x, negate_in,
    input  in_ready, valid_out, t, negate_out
  );

  modport slave (
    input  valid_in, x, negate_in,
    output in_ready, valid_out, t, negate_out
  );
endinterface

`default_nettype wire

// File: rtl/fx_invcdf_sqrt.sv
//----------------------------------------------------------------------------
// Module : fx_invcdf_sqrt
// Brief  : Sequential digit-recurrence sqrt of -2*ln(p) for the inverse-CDF path
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module fx_invcdf_sqrt #(
  parameter int WIDTH = 32,
  parameter int QFRAC = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  fx_invcdf_sqrt_if.slave  io
);

  localparam int RW      = WIDTH + QFRAC;
  localparam int ITER    = RW / 2;
  localparam int LATENCY = ITER + 1;
  localparam int CW      = $clog2(LATENCY);

  localparam logic [CW-1:0] c_CNT_INIT = CW'(ITER - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  if ((RW % 2) != 0) begin : g_bad_qfrac
    $error("fx_invcdf_sqrt: WIDTH+QFRAC must be even");
  end

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [RW-1:0]    r_rad;
  logic [ITER+1:0]  r_rem;
  logic [ITER-1:0]  r_root;
  logic             r_neg;
  logic             r_valid_out;
  logic [WIDTH-1:0] r_t;
  logic             r_neg_out;

  // Shifted remainder is kept two bits wider than r_rem so the trial
  // comparison sees every bit; the bound rem <= 2*root keeps those bits zero.
  logic [ITER+3:0]  w_rem_sh;
  logic [ITER+3:0]  w_sub;
  logic             w_ge;
  logic [ITER+1:0]  w_trial;

  assign w_rem_sh = {r_rem, r_rad[RW-1 -: 2]};
  assign w_sub    = {2'b00, r_root, 2'b01};
  assign w_ge     = (w_rem_sh >= w_sub);
  assign w_trial  = w_rem_sh[ITER+1:0] - w_sub[ITER+1:0];

  assign io.in_ready   = (r_state == c_IDLE);
  assign io.valid_out  = r_valid_out;
  assign io.t          = r_t;
  assign io.negate_out = r_neg_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_cnt       <= '0;
      r_rad       <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_neg       <= 1'b0;
      r_valid_out <= 1'b0;
      r_t         <= '0;
      r_neg_out   <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (io.valid_in) begin
            r_rad   <= {io.x, {QFRAC{1'b0}}};
            r_rem   <= '0;
            r_root  <= '0;
            r_neg   <= io.negate_in;
            r_cnt   <= c_CNT_INIT;
            r_state <= c_CALC;
          end
        end
        c_CALC: begin
          r_rad <= {r_rad[RW-3:0], 2'b00};
          if (w_ge) begin
            r_rem  <= w_trial;
            r_root <= {r_root[ITER-2:0], 1'b1};
          end else begin
            r_rem  <= w_rem_sh[ITER+1:0];
            r_root <= {r_root[ITER-2:0], 1'b0};
          end
          if (r_cnt == '0) begin
            r_state <= c_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        c_DONE: begin
          r_t         <= WIDTH'(r_root);
          r_neg_out   <= r_neg;
          r_valid_out <= 1'b1;
          r_state     <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fx_invcdf_sqrt.sv
// Directed-vector and sequence bench for fx_invcdf_sqrt at WIDTH=32, QFRAC=16.
`default_nettype none

module tb_fx_invcdf_sqrt;

  typedef struct {
    logic [31:0] x;
    logic        neg;
    logic [31:0] exp_t;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  fx_invcdf_sqrt_if #(.WIDTH(32)) bus ();

  fx_invcdf_sqrt #(.WIDTH(32), .QFRAC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Golden model by binary search on r*r <= x*2^16
  function automatic logic [31:0] ref_sqrt(input logic [31:0] xv);
    longint unsigned v, lo, hi, mid;
    v  = {16'h0, xv, 16'h0};
    lo = 0;
    hi = 64'd1 << 24;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid;
    end
    return lo[31:0];
  endfunction

  // One sample: checks busy flag, latency 25, result, flag, pulse width, hold.
  task automatic run_one(input logic [31:0] xv, input logic neg, input logic [31:0] exp_t,
                         input string name);
    int w;
    int lat;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_ready"}, 64'(bus.in_ready), 64'd1);
    bus.x         = xv;
    bus.negate_in = neg;
    bus.valid_in  = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in  = 1'b0;
    bus.x         = ~xv;
    bus.negate_in = ~neg;
    chk({name, "_busy"}, 64'(bus.in_ready), 64'd0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.valid_out && lat < 40);
    chk({name, "_lat"}, 64'(lat), 64'd25);
    chk({name, "_t"}, 64'(bus.t), 64'(exp_t));
    chk({name, "_neg"}, 64'(bus.negate_out), 64'(neg));
    chk({name, "_rdy_out"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk({name, "_pulse"}, 64'(bus.valid_out), 64'd0);
    chk({name, "_hold"}, 64'(bus.t), 64'(exp_t));
  endtask

  vec_t vecs[10];
  vec_t q[$];
  vec_t e;
  int   got;
  int   pulses;
  logic [31:0] rx;
  logic        rn;

  initial begin
    n_checks = 0;
    n_err    = 0;
    vecs[0] = '{32'h0004_0000, 1'b1, 32'h0002_0000};
    vecs[1] = '{32'h0002_0000, 1'b0, 32'h0001_6A09};
    vecs[2] = '{32'h0000_0001, 1'b1, 32'h0000_0100};
    vecs[3] = '{32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 1'b1, 32'h00FF_FFFF};
    vecs[5] = '{32'h0001_0000, 1'b0, 32'h0001_0000};
    vecs[6] = '{32'h0009_0000, 1'b1, 32'h0003_0000};
    vecs[7] = '{32'h0000_0002, 1'b0, 32'h0000_016A};
    vecs[8] = '{32'h0000_0003, 1'b1, 32'h0000_01BB};
    vecs[9] = '{32'h0010_0000, 1'b0, 32'h0004_0000};

    rst_n         = 1'b0;
    bus.valid_in  = 1'b1;
    bus.x         = 32'h0004_0000;
    bus.negate_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_valid", 64'(bus.valid_out), 64'd0);
    chk("rst_t", 64'(bus.t), 64'd0);
    chk("rst_neg", 64'(bus.negate_out), 64'd0);
    bus.valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_one(vecs[i].x, vecs[i].neg, vecs[i].exp_t, $sformatf("vec%0d", i));
    end

    // valid_in held high: only in_ready-high edges accept
    got = 0;
    bus.valid_in = 1'b1;
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      bus.x         = $urandom;
      bus.negate_in = 1'($urandom_range(0, 1));
      if (bus.in_ready) q.push_back('{bus.x, bus.negate_in, ref_sqrt(bus.x)});
      @(posedge clk);
      #1;
      if (bus.valid_out) begin
        got++;
        if (q.size() == 0) chk("sus_extra", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("sus_t", 64'(bus.t), 64'(e.exp_t));
          chk("sus_neg", 64'(bus.negate_out), 64'(e.neg));
        end
      end
    end
    bus.valid_in = 1'b0;
    for (int c = 0; c < 60 && q.size() > 0; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid_out) begin
        got++;
        e = q.pop_front();
        chk("sus_t", 64'(bus.t), 64'(e.exp_t));
        chk("sus_neg", 64'(bus.negate_out), 64'(e.neg));
      end
    end
    chk("sus_count", 64'(got), 64'd6);
    chk("sus_drain", 64'(q.size()), 64'd0);

    // Reset ten edges into a calculation aborts it
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.x         = 32'h0009_0000;
    bus.negate_in = 1'b1;
    bus.valid_in  = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(bus.valid_out), 64'd0);
    chk("abort_t", 64'(bus.t), 64'd0);
    chk("abort_neg", 64'(bus.negate_out), 64'd0);
    chk("abort_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_hold_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.valid_in = 1'b0;
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid_out) pulses++;
    end
    chk("abort_no_pulse", 64'(pulses), 64'd0);
    run_one(32'h0004_0000, 1'b1, 32'h0002_0000, "post_rst");

    for (int i = 0; i < 300; i++) begin
      rx = $urandom;
      if (i % 4 == 0) rx = rx >> $urandom_range(0, 31);
      rn = 1'($urandom_range(0, 1));
      run_one(rx, rn, ref_sqrt(rx), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/fx_invcdf_sqrt.md
FX_INVCDF_SQRT -- requirements
Module: fx_invcdf_sqrt

Interface
REQ-001 SHALL have parameter WIDTH, default fpga_cfg_pkg::FP_WIDTH (32), total fixed-point width.
REQ-002 SHALL have parameter QFRAC, default fpga_cfg_pkg::FP_QFRAC (16), fractional bits; WIDTH+QFRAC SHALL be even (elaboration error otherwise).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port valid_in  input  1  input sample valid.
REQ-006 SHALL have port x  input  WIDTH  unsigned radicand, -2*ln(p), Q(WIDTH-QFRAC).QFRAC.
REQ-007 SHALL have port negate_in  input  1  tail sign flag from the fold stage (u > 0.5).
REQ-008 SHALL have port in_ready  output  1  block can accept a sample this cycle.
REQ-009 SHALL have port valid_out  output  1  one-cycle pulse, t/negate_out valid.
REQ-010 SHALL have port t  output  WIDTH  unsigned sqrt(x), same Q format; feeds the Zelen-Severo inverse-CDF stage.
REQ-011 SHALL have port negate_out  output  1  negate_in of the same sample, aligned with t.

Function
REQ-012 SHALL define ITER = (WIDTH+QFRAC)/2 and LATENCY = ITER+1 (24 and 25 at defaults).
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; in_ready SHALL equal (state == IDLE), combinationally.
REQ-014 Acceptance SHALL occur on an edge where valid_in && in_ready; valid_in while not in IDLE SHALL be ignored (no queueing, no error).
REQ-015 On acceptance (edge k): radicand register SHALL load {x, QFRAC zeros} (WIDTH+QFRAC bits), remainder and root SHALL clear, negate_in SHALL be captured, iteration counter SHALL load ITER-1, state -> CALC.
REQ-016 In CALC, each edge SHALL perform one non-restoring/restoring digit-recurrence step: shift 2 radicand MSBs into remainder, trial = remainder - {root,2'b01}; if trial >= 0 keep trial and shift 1 into root, else keep remainder and shift 0.
REQ-017 Remainder SHALL be ITER+2 bits, root ITER bits; no intermediate overflow SHALL be possible.
REQ-018 On the edge completing iteration ITER (edge k+ITER), state -> DONE.
REQ-019 On edge k+ITER+1 (DONE): t <= zero-extended root, negate_out <= captured flag, valid_out <= 1, state -> IDLE.
REQ-020 valid_out SHALL be high for exactly one cycle per accepted sample and 0 otherwise.
REQ-021 Result SHALL be floor(sqrt(x * 2^QFRAC)) exactly (truncation, no rounding); bits above ITER in t SHALL be 0.
REQ-022 t and negate_out SHALL hold their last values until the next valid_out.
REQ-023 Next acceptance earliest at edge k+ITER+2 (in_ready high during the valid_out cycle); sustained throughput one sample per ITER+2 cycles.
REQ-024 x = 0 SHALL yield t = 0; x = all-ones SHALL yield t = 2^ITER - 1 without wrap.
REQ-025 The block SHALL NOT support backpressure on the output; downstream consumes every valid_out pulse.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, valid_out 0, t 0, negate_out 0, counter/remainder/root/radicand 0.
REQ-027 Reset asserted mid-CALC SHALL abort the sample with no valid_out ever produced for it.
REQ-028 While rst_n is low, valid_in SHALL be ignored; first acceptance possible on the first rising edge after rst_n deasserts.

Verification
REQ-029 x=0x00040000 (4.0), negate_in=1 at edge k -> valid_out single pulse after edge k+25, t=0x00020000, negate_out=1.
REQ-030 x=0x00020000 (2.0) -> t=0x00016A09; x=0x00000001 -> t=0x00000100; x=0 -> t=0.
REQ-031 x=0xFFFFFFFF -> t=0x00FFFFFF, no overflow; x=0x00010000 -> t=0x00010000.
REQ-032 valid_in held high continuously with changing x -> only samples at in_ready-high edges accepted, one result per 26 cycles, each matching floor reference model and its own negate.
REQ-033 rst_n pulsed low at edge k+10 of a sample -> outputs zero immediately, no valid_out for that sample, next sample after reset correct.
REQ-034 Random x (10k samples) against floor(sqrt(x*65536)) golden model -> zero mismatches, negate_out always matches its sample.
